ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 97 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller that drives an external registered-read RAM.
// Define RAM_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 8,
  parameter int DATA_ADDR  = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [DATA_ADDR-1:0]  ram_wr_addr,
  output logic [DATA_ADDR-1:0]  ram_rd_addr,
  output logic [DATA_WIDTH-1:0] ram_d_in,
  input  logic [DATA_WIDTH-1:0] ram_d_out,
  output logic                  ram_clear,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_ADDR:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [DATA_ADDR-1:0] LAST_ADDR  = DATA_ADDR'(DATA_DEPTH - 1);
  localparam logic [DATA_ADDR-1:0] PTR_ONE    = DATA_ADDR'(1);
  localparam logic [DATA_ADDR:0]   FULL_COUNT = (DATA_ADDR + 1)'(DATA_DEPTH);
  localparam logic [DATA_ADDR:0]   COUNT_ONE  = (DATA_ADDR + 1)'(1);

  logic [DATA_ADDR-1:0] wr_ptr;
  logic [DATA_ADDR-1:0] rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Acceptance is gated by the registered status, so an empty FIFO never falls through.
  assign push_ok = push & ~full  & ~flush & ~clear;
  assign pop_ok  = pop  & ~empty & ~flush & ~clear;

  assign ram_we      = push_ok;
  assign ram_re      = pop_ok;
  assign ram_wr_addr = wr_ptr;
  assign ram_rd_addr = rd_ptr;
  assign ram_d_in    = push_data;
  assign ram_clear   = clear;
  assign pop_data    = ram_d_out;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (push_ok) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef RAM_FIFO_ERR_EN
  // A pop on empty that coincides with a push is an ordinary rejection, not an underflow.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)          overflow  <= 1'b1;
      if (pop & empty & ~push)  underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural registered-read RAM.
// Honours RAM_FIFO_ERR_EN the same way as the design.
module tb_ram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        push;
  logic [15:0] push_data;
  logic        pop;
  logic        flush;
  logic        ram_we;
  logic        ram_re;
  logic [2:0]  ram_wr_addr;
  logic [2:0]  ram_rd_addr;
  logic [15:0] ram_d_in;
  logic [15:0] ram_d_out;
  logic        ram_clear;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  // Bench-side reference state
  logic [15:0] m_q[$];
  int          m_count = 0;
  logic [2:0]  m_wr = 3'd0;
  logic [2:0]  m_rd = 3'd0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_data = 16'h0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  logic [15:0] mem [8];

  ram_fifo_ctrl #(.DATA_WIDTH(16), .DATA_DEPTH(8), .DATA_ADDR(3)) dut (
    .clk(clk), .clear(clear), .push(push), .push_data(push_data), .pop(pop),
    .flush(flush), .ram_we(ram_we), .ram_re(ram_re), .ram_wr_addr(ram_wr_addr),
    .ram_rd_addr(ram_rd_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out),
    .ram_clear(ram_clear), .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge ram_clear) begin
    if (ram_clear) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h0;
      ram_d_out <= 16'h0;
    end else begin
      if (ram_we) mem[ram_wr_addr] <= ram_d_in;
      if (ram_re) ram_d_out <= mem[ram_rd_addr];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic model_reset();
    m_q.delete();
    m_count   = 0;
    m_wr      = 3'd0;
    m_rd      = 3'd0;
    exp_valid = 1'b0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  // One clock of stimulus: checks the RAM strobes before the edge, status after it.
  task automatic step(input logic p, input logic [15:0] d, input logic q, input logic f);
    logic acc_push, acc_pop;
    push = p; push_data = d; pop = q; flush = f;
    acc_push = p && !f && (m_count < 8);
    acc_pop  = q && !f && (m_count > 0);
    #1;
    total++;
    if (ram_we !== acc_push) begin bad++; $display("[TB] FAIL ram_we got=%b exp=%b", ram_we, acc_push); end
    total++;
    if (ram_re !== acc_pop) begin bad++; $display("[TB] FAIL ram_re got=%b exp=%b", ram_re, acc_pop); end
    if (acc_push) begin
      total++;
      if (ram_wr_addr !== m_wr || ram_d_in !== d) begin
        bad++; $display("[TB] FAIL wr_port got=%0d/%h exp=%0d/%h", ram_wr_addr, ram_d_in, m_wr, d);
      end
    end
    if (acc_pop) begin
      total++;
      if (ram_rd_addr !== m_rd) begin bad++; $display("[TB] FAIL rd_addr got=%0d exp=%0d", ram_rd_addr, m_rd); end
    end
    @(posedge clk);
    if (f) begin
      model_reset();
    end else begin
`ifdef RAM_FIFO_ERR_EN
      if (p && m_count == 8) m_ovf = 1'b1;
      if (q && !p && m_count == 0) m_udf = 1'b1;
`endif
      exp_valid = acc_pop;
      if (acc_pop) begin
        exp_data = m_q.pop_front();
        m_rd++;
        m_count--;
      end
      if (acc_push) begin
        m_q.push_back(d);
        m_wr++;
        m_count++;
      end
    end
    #1;
    total++;
    if (pop_valid !== exp_valid) begin bad++; $display("[TB] FAIL pop_valid got=%b exp=%b", pop_valid, exp_valid); end
    if (exp_valid) begin
      total++;
      if (pop_data !== exp_data) begin bad++; $display("[TB] FAIL pop_data got=%h exp=%h", pop_data, exp_data); end
    end
    total++;
    if (count !== 4'(m_count) || full !== (m_count == 8) || empty !== (m_count == 0)) begin
      bad++; $display("[TB] FAIL status got=%0d/%b/%b exp=%0d", count, full, empty, m_count);
    end
    total++;
    if (overflow !== m_ovf || underflow !== m_udf) begin
      bad++; $display("[TB] FAIL flags got=%b/%b exp=%b/%b", overflow, underflow, m_ovf, m_udf);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; push = 1'b1; push_data = 16'h1234; pop = 1'b1; flush = 1'b0;
    #12;
    total++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_status got=%0d/%b/%b/%b exp=0/1/0/0", count, empty, full, pop_valid);
    end
    total++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0 || ram_clear !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_ram got=%b/%b/%b exp=0/0/1", ram_we, ram_re, ram_clear);
    end
    total++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b/%b exp=0/0", overflow, underflow);
    end
    push = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    total++;
    if (ram_clear !== 1'b0) begin bad++; $display("[TB] FAIL ram_clear got=%b exp=0", ram_clear); end
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    total++;
    if (full !== 1'b1 || count !== 4'd8) begin
      bad++; $display("[TB] FAIL fill_full got=%b/%0d exp=1/8", full, count);
    end
    step(1'b1, 16'hA009, 1'b0, 1'b0);
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 3; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
    for (int i = 3; i < 23; i++) step(1'b1, 16'hB000 + 16'(i), 1'b1, 1'b0);
    total++;
    if (count !== 4'd3) begin bad++; $display("[TB] FAIL interleave_count got=%0d exp=3", count); end
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'hCFFF, 1'b1, 1'b0);
    total++;
    if (count !== 4'd7) begin bad++; $display("[TB] FAIL full_pushpop got=%0d exp=7", count); end
    for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'hD00D, 1'b1, 1'b0);
    total++;
    if (count !== 4'd1 || pop_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL empty_pushpop got=%0d/%b exp=1/0", count, pop_valid);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    step(1'b1, 16'hE001, 1'b0, 1'b0);
    step(1'b1, 16'hE002, 1'b0, 1'b0);
    push = 1'b0; pop = 1'b1; flush = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    total++;
    if (count !== 4'd0 || empty !== 1'b1 || pop_valid !== 1'b0 || ram_re !== 1'b0 || ram_we !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_async got=%0d/%b/%b/%b exp=0/1/0/0", count, empty, pop_valid, ram_re);
    end
    pop = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    @(posedge clk); #1;
    total++;
    if (pop_valid !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("[TB] FAIL clear_cancel got=%b/%b exp=0/1", pop_valid, empty);
    end
  endtask

  task automatic test_flags();
    step(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
`ifdef RAM_FIFO_ERR_EN
    total++;
    if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL underflow_held got=%b exp=1", underflow); end
`else
    total++;
    if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL underflow_tied got=%b exp=0", underflow); end
`endif
    step(1'b1, 16'hF001, 1'b0, 1'b0);
    step(1'b1, 16'hF002, 1'b1, 1'b1);
    total++;
    if (underflow !== 1'b0 || count !== 4'd0) begin
      bad++; $display("[TB] FAIL flush got=%b/%0d exp=0/0", underflow, count);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_interleave();
    test_back_to_back();
    test_clear();
    test_flags();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
